// File: rtl/seg7_defs.vh
// Shared pattern and class constants for the seg7_reader decode path (hex decoding: SEG7_READER_HEX_DIGITS_EN).
// Classes are 5 bits: bit4 clear carries a digit value in [3:0]; bit4 set marks BLANK or ILLEGAL.
localparam logic [4:0] CLS_BLANK   = 5'b10000;
localparam logic [4:0] CLS_ILLEGAL = 5'b10001;

`ifndef SEG7_DEFS_CLASSES_ONLY
// Patterns are listed as H[0:6], active-low, segment 6 is the middle bar.
localparam logic [0:6] P0     = 7'b0000001;
localparam logic [0:6] P1     = 7'b1001111;
localparam logic [0:6] P2     = 7'b0010010;
localparam logic [0:6] P3     = 7'b0000110;
localparam logic [0:6] P4     = 7'b1001100;
localparam logic [0:6] P5     = 7'b0100100;
localparam logic [0:6] P6     = 7'b0100000;
localparam logic [0:6] P6ALT  = 7'b1100000;
localparam logic [0:6] P7     = 7'b0001111;
localparam logic [0:6] P8     = 7'b0000000;
localparam logic [0:6] P9     = 7'b0000100;
localparam logic [0:6] P9ALT  = 7'b0001100;
localparam logic [0:6] PBLANK = 7'b1111111;
localparam logic [0:6] PA     = 7'b0001000;
localparam logic [0:6] PB     = 7'b1100000;
localparam logic [0:6] PC     = 7'b0110001;
localparam logic [0:6] PD     = 7'b1000010;
localparam logic [0:6] PE     = 7'b0110000;
localparam logic [0:6] PF     = 7'b0111000;
`endif

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to class decoder.
// SEG7_READER_HEX_DIGITS_EN adds A..F; without it 1100000 is the alternate 6.
module seg7_pattern_decode (
    input  logic [0:6] i_h,
    output logic [4:0] o_class
);
`include "seg7_defs.vh"

    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_h)
            P0:     o_class = 5'd0;
            P1:     o_class = 5'd1;
            P2:     o_class = 5'd2;
            P3:     o_class = 5'd3;
            P4:     o_class = 5'd4;
            P5:     o_class = 5'd5;
            P6:     o_class = 5'd6;
            P7:     o_class = 5'd7;
            P8:     o_class = 5'd8;
            P9:     o_class = 5'd9;
            P9ALT:  o_class = 5'd9;
            PBLANK: o_class = CLS_BLANK;
`ifdef SEG7_READER_HEX_DIGITS_EN
            PA:     o_class = 5'd10;
            PB:     o_class = 5'd11;
            PC:     o_class = 5'd12;
            PD:     o_class = 5'd13;
            PE:     o_class = 5'd14;
            PF:     o_class = 5'd15;
`else
            // PB shares its pattern with P6ALT, so it reads as a 6 here.
            P6ALT:  o_class = 5'd6;
            PA, PC, PD, PE, PF: o_class = CLS_ILLEGAL;
`endif
            default: o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus with a per-digit stability filter.
// Optional hex digit decoding is enabled by defining SEG7_READER_HEX_DIGITS_EN.
module seg7_reader #(
    parameter int STABLE = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_strobe,
    input  logic [1:0]  i_sel,
    input  logic [0:6]  i_h,
    input  logic        i_err_clr,
    output logic [15:0] o_bcd,
    output logic [3:0]  o_valid,
    output logic        o_err,
    output logic        o_update
);
`define SEG7_DEFS_CLASSES_ONLY
`include "seg7_defs.vh"
`undef SEG7_DEFS_CLASSES_ONLY

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [4:0]  w_class;
    logic [4:0]  w_cand [4];
    logic [3:0]  w_cnt  [4];
    logic [4:0]  w_cur_cand;
    logic [3:0]  w_cur_cnt;
    logic        w_same;
    logic        w_sat;
    logic [3:0]  w_cnt_next;
    logic        w_commit;
    logic [15:0] w_bcd_next;
    logic [3:0]  w_valid_next;
    logic        w_err_set;

    logic [15:0] r_bcd;
    logic [3:0]  r_valid;
    logic        r_err;
    logic        r_update;

    seg7_pattern_decode u_decode (
        .i_h     (i_h),
        .o_class (w_class)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [4:0] r_cand;
            logic [3:0] r_cnt;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_cand <= CLS_BLANK;
                    r_cnt  <= '0;
                end else if (i_strobe && (i_sel == 2'(gi))) begin
                    r_cand <= w_class;
                    r_cnt  <= w_cnt_next;
                end
            end

            assign w_cand[gi] = r_cand;
            assign w_cnt[gi]  = r_cnt;
        end
    endgenerate

    assign w_cur_cand = w_cand[i_sel];
    assign w_cur_cnt  = w_cnt[i_sel];
    assign w_same     = (w_class == w_cur_cand);
    assign w_sat      = (w_cur_cnt == STABLE_C);
    assign w_cnt_next = !w_same ? 4'd1 : (w_sat ? w_cur_cnt : w_cur_cnt + 4'd1);
    // A saturated repeat must not re-commit, otherwise Err could re-arm after a clear.
    assign w_commit   = i_strobe && (w_cnt_next == STABLE_C) && !(w_same && w_sat);

    always_comb begin
        w_bcd_next   = r_bcd;
        w_valid_next = r_valid;
        w_err_set    = 1'b0;
        if (w_commit) begin
            if (!w_class[4]) begin
                w_bcd_next[{i_sel, 2'b00} +: 4] = w_class[3:0];
                w_valid_next[i_sel]             = 1'b1;
            end else begin
                w_valid_next[i_sel] = 1'b0;
                w_err_set           = (w_class == CLS_ILLEGAL);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bcd    <= '0;
            r_valid  <= '0;
            r_err    <= 1'b0;
            r_update <= 1'b0;
        end else begin
            r_bcd    <= w_bcd_next;
            r_valid  <= w_valid_next;
            r_update <= (w_bcd_next != r_bcd) || (w_valid_next != r_valid);
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_bcd    = r_bcd;
    assign o_valid  = r_valid;
    assign o_err    = r_err;
    assign o_update = r_update;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: a behavioural model queues expected outputs per driven cycle.
// Follows SEG7_READER_HEX_DIGITS_EN so the model matches the build being simulated.
module tb_seg7_reader;
    localparam int STABLE = 3;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  valid;
        logic        err;
        logic        upd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [6:0]  h = 7'b1111111;
    logic        err_clr = 1'b0;
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic        err;
    logic        update;

    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];

    logic [4:0]  m_cand [4];
    int          m_cnt  [4];
    logic [15:0] m_bcd;
    logic [3:0]  m_valid;
    logic        m_err;
    logic [6:0]  pool [14];

    seg7_reader #(.STABLE(STABLE)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_strobe  (strobe),
        .i_sel     (sel),
        .i_h       (h),
        .i_err_clr (err_clr),
        .o_bcd     (bcd),
        .o_valid   (valid),
        .o_err     (err),
        .o_update  (update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference decode: -1 for illegal, -2 for blank, else digit value.
    function automatic int ref_decode(input logic [6:0] p);
        case (p)
            7'b0000001: return 0;
            7'b1001111: return 1;
            7'b0010010: return 2;
            7'b0000110: return 3;
            7'b1001100: return 4;
            7'b0100100: return 5;
            7'b0100000: return 6;
            7'b0001111: return 7;
            7'b0000000: return 8;
            7'b0001100, 7'b0000100: return 9;
            7'b1111111: return -2;
`ifdef SEG7_READER_HEX_DIGITS_EN
            7'b0001000: return 10;
            7'b1100000: return 11;
            7'b0110001: return 12;
            7'b1000010: return 13;
            7'b0110000: return 14;
            7'b0111000: return 15;
`else
            7'b1100000: return 6;
`endif
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_cand[d] = 5'b10000;
            m_cnt[d]  = 0;
        end
        m_bcd   = '0;
        m_valid = '0;
        m_err   = 1'b0;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic cyc(input logic s, input logic [1:0] d, input logic [6:0] p, input logic clr);
        int          v;
        logic [4:0]  cls;
        logic        commit;
        logic [15:0] old_bcd;
        logic [3:0]  old_valid;
        exp_t        e;
        @(negedge clk);
        strobe  = s;
        sel     = d;
        h       = p;
        err_clr = clr;
        old_bcd   = m_bcd;
        old_valid = m_valid;
        commit    = 1'b0;
        v   = ref_decode(p);
        cls = (v == -2) ? 5'b10000 : (v == -1) ? 5'b10001 : 5'(v);
        if (s) begin
            if (cls == m_cand[d]) begin
                if (m_cnt[d] < STABLE) begin
                    m_cnt[d] = m_cnt[d] + 1;
                    commit = (m_cnt[d] == STABLE);
                end
            end else begin
                m_cand[d] = cls;
                m_cnt[d]  = 1;
                commit = (STABLE == 1);
            end
        end
        if (commit && v >= 0) begin
            m_bcd[d*4 +: 4] = v[3:0];
            m_valid[d]      = 1'b1;
        end else if (commit) begin
            m_valid[d] = 1'b0;
        end
        if (commit && v == -1) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        e.bcd   = m_bcd;
        e.valid = m_valid;
        e.err   = m_err;
        e.upd   = (m_bcd != old_bcd) || (m_valid != old_valid);
        exp_q.push_back(e);
    endtask

    task automatic rep(input int n, input logic [1:0] d, input logic [6:0] p);
        for (int i = 0; i < n; i++) cyc(1'b1, d, p, 1'b0);
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_bcd", 32'(bcd), 32'(e.bcd));
            check("sb_valid", 32'(valid), 32'(e.valid));
            check("sb_err", 32'(err), 32'(e.err));
            check("sb_update", 32'(update), 32'(e.upd));
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pool[0]  = 7'b0000001; pool[1]  = 7'b1001111; pool[2]  = 7'b0010010;
        pool[3]  = 7'b0100000; pool[4]  = 7'b1100000; pool[5]  = 7'b0001100;
        pool[6]  = 7'b1111111; pool[7]  = 7'b1111110; pool[8]  = 7'b0001000;
        pool[9]  = 7'b0110001; pool[10] = 7'b0000000; pool[11] = 7'b0111000;
        pool[12] = 7'b0000100; pool[13] = 7'b0001111;
        model_reset();
        #3;
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_update", 32'(update), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        rep(3, 2'd2, 7'b0010010);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t1_digit2", 32'(bcd[11:8]), 32'd2);
        check("t1_valid", 32'(valid), 32'b0100);
        check("t1_update", 32'(update), 32'd1);
        rep(1, 2'd2, 7'b0010010);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t1_no_repulse", 32'(update), 32'd0);

        rep(2, 2'd0, 7'b0000110);
        rep(1, 2'd0, 7'b1001100);
        rep(2, 2'd0, 7'b0000110);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t2_not_yet", 32'(valid[0]), 32'd0);
        rep(1, 2'd0, 7'b0000110);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t2_digit0", 32'(bcd[3:0]), 32'd3);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'd0, 7'b1001111, 1'b0);
            cyc(1'b1, 2'd1, 7'b0000000, 1'b0);
        end
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t3_low_byte", 32'(bcd[7:0]), 32'h81);
        check("t3_valid", 32'(valid[1:0]), 32'b11);

        rep(3, 2'd3, 7'b1111110);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t4_err_set", 32'(err), 32'd1);
        check("t4_valid3", 32'(valid[3]), 32'd0);
        rep(1, 2'd3, 7'b1111111);
        rep(2, 2'd3, 7'b1111110);
        cyc(1'b1, 2'd3, 7'b1111110, 1'b1);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t4_set_wins", 32'(err), 32'd1);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b1);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t4_cleared", 32'(err), 32'd0);

        rep(3, 2'd1, 7'b1100000);
        rep(3, 2'd2, 7'b0001000);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
`ifdef SEG7_READER_HEX_DIGITS_EN
        check("t5_b", 32'(bcd[7:4]), 32'hB);
        check("t5_a", 32'(bcd[11:8]), 32'hA);
        check("t5_err", 32'(err), 32'd0);
`else
        check("t5_six", 32'(bcd[7:4]), 32'd6);
        check("t5_err", 32'(err), 32'd1);
        check("t5_valid2", 32'(valid[2]), 32'd0);
`endif

        rep(3, 2'd0, 7'b1111111);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t6_blank_valid", 32'(valid[0]), 32'd0);
        check("t6_blank_keep", 32'(bcd[3:0]), 32'd1);
        check("t6_blank_upd", 32'(update), 32'd1);

        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                pool[$urandom_range(0, 13)], 1'($urandom_range(0, 15) == 0));
        end

        rep(3, 2'd3, 7'b0000001);
        rep(2, 2'd3, 7'b0001111);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t7_rst_bcd", 32'(bcd), 32'h0);
        check("t7_rst_valid", 32'(valid), 32'h0);
        check("t7_rst_update", 32'(update), 32'h0);
        model_reset();
        @(negedge clk);
        strobe = 1'b0;
        rst    = 1'b0;
        rep(1, 2'd3, 7'b0001111);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        check("t7_count_dropped", 32'(valid[3]), 32'd0);
        rep(2, 2'd3, 7'b0001111);
        cyc(1'b0, 2'd0, 7'b1111111, 1'b0);
        @(posedge clk);
        #2;
        check("t7_recommit", 32'(bcd[15:12]), 32'd7);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
